instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction decoder.
- Owns the program counter and fetches each instruction word from instruction memory through a req/ready handshake. It holds the word stable for exactly one execute cycle while the decoder and datapath evaluate it.
- On that cycle it consumes the decoder's Branch/Jump/JumpReg/InvZero flags, the ALU Zero flag and register operand Da, and computes the next PC.
- Sticky fault detection covers instruction-memory timeout and misaligned targets.

---
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Owns the program counter. Fetches one instruction word at a time from
// instruction memory over a req/ready handshake. Holds that word for exactly
// one EXEC cycle while the decoder and datapath evaluate it. Then computes the
// next PC from the decoder flags, the ALU Zero flag and register operand Da.
// Memory timeouts and misaligned targets park the unit in a sticky FAULT
// state, which only reset clears.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and byte address (high only in FETCH)
//   imem_ready/imem_rdata memory response, only looked at in FETCH
//   instruction           held instruction word for the decoder
//   instr_valid           high for the single EXEC cycle
//   pc, pc_plus4          address of held instruction and its link value
//   Branch, Jump, JumpReg, InvZero, Zero, Da
//                         next-PC controls, only looked at in EXEC
//   instr_count           retired-instruction counter (wraps)
//   fault, fault_code     sticky fault flag, 01 = imem timeout, 10 = misaligned
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        InvZero,
    input  logic        Zero,
    input  logic [31:0] Da,
    output logic [31:0] instr_count,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_e;

    // The timeout counter holds the number of FETCH cycles already spent
    // waiting. Reaching the last value with ready still low means this is the
    // IMEM_TIMEOUT-th consecutive waiting cycle.
    localparam logic [7:0] TOUT_LAST = 8'(IMEM_TIMEOUT - 1);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instrCount_q;
    logic [7:0]  toutCnt_q;
    logic        fault_q;
    logic [1:0]  faultCode_q;

    logic [31:0] pcPlus4;
    logic [31:0] branchOffset;
    logic        branchTaken;
    logic [31:0] nextPc_d;

    assign pcPlus4      = pc_q + 32'd4;
    assign branchOffset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign branchTaken  = Branch & (Zero ^ InvZero);

    // Next-PC selection. Priority order resolves conflicting flags.
    // jr beats jal, and jal beats a taken branch. Fall-through wraps
    // naturally at the top of the address space.
    always_comb begin
        nextPc_d = pcPlus4;
        if (JumpReg) begin
            nextPc_d = Da;
        end else if (Jump) begin
            nextPc_d = {pcPlus4[31:28], instr_q[25:0], 2'b00};
        end else if (branchTaken) begin
            nextPc_d = pcPlus4 + branchOffset;
        end
    end

    // Fetch/execute sequencer.
    // Reset dominates, so any memory response that arrives during a reset
    // cycle is dropped. A misaligned target is caught before it reaches the
    // PC, so pc still names the instruction that produced it. FAULT freezes
    // everything until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            instrCount_q <= '0;
            toutCnt_q    <= '0;
            fault_q      <= 1'b0;
            faultCode_q  <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr_q   <= imem_rdata;
                        toutCnt_q <= '0;
                        state_q   <= EXEC;
                    end else if (toutCnt_q == TOUT_LAST) begin
                        fault_q     <= 1'b1;
                        faultCode_q <= 2'b01;
                        state_q     <= FAULT;
                    end else begin
                        toutCnt_q <= toutCnt_q + 8'd1;
                    end
                end
                EXEC: begin
                    if (nextPc_d[1:0] == 2'b00) begin
                        pc_q         <= nextPc_d;
                        instrCount_q <= instrCount_q + 32'd1;
                        state_q      <= FETCH;
                    end else begin
                        fault_q     <= 1'b1;
                        faultCode_q <= 2'b10;
                        state_q     <= FAULT;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pcPlus4;
    assign instr_count = instrCount_q;
    assign fault       = fault_q;
    assign fault_code  = faultCode_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives the fetch unit like a memory plus decoder would. Inputs change on
// the falling edge and outputs are sampled there too. The reference model
// tracks the program at instruction granularity: expected PC, retired count
// and fault state, updated with plain arithmetic from the next-PC rules.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          IMEM_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        Branch, Jump, JumpReg, InvZero, Zero;
    logic [31:0] Da;
    logic [31:0] instr_count;
    logic        fault;
    logic [1:0]  fault_code;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] mPc;
    logic [31:0] mCount;
    logic        mFault;

    instruction_fetch_unit #(
        .RESET_PC     (RESET_PC),
        .IMEM_TIMEOUT (IMEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .Branch      (Branch),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .InvZero     (InvZero),
        .Zero        (Zero),
        .Da          (Da),
        .instr_count (instr_count),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    // Safety net in case something upstream of the bounded waits misbehaves
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearFlags();
        Branch  = 1'b0;
        Jump    = 1'b0;
        JumpReg = 1'b0;
        InvZero = 1'b0;
        Zero    = 1'b0;
        Da      = 32'h0;
    endtask

    // Reset for one edge and return the model to its power-on view
    task automatic doReset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        clearFlags();
        @(negedge clk);
        reset  = 1'b0;
        mPc    = RESET_PC;
        mCount = 32'h0;
        mFault = 1'b0;
        checkOutput("rstPc",    pc, RESET_PC);
        checkOutput("rstInstr", instruction, 32'h0);
        checkOutput("rstCount", instr_count, 32'h0);
        checkOutput("rstFault", {30'h0, fault_code}, 32'h0);
        checkOutput("rstFlag",  fault, 1'b0);
        checkOutput("rstReq",   imem_req, 1'b0);
        checkOutput("rstValid", instr_valid, 1'b0);
    endtask

    // Run one instruction. Memory answers after `delay` empty FETCH cycles,
    // then the decoder presents the given flags during EXEC.
    task automatic applyStimulus(input int delay, input logic [31:0] word,
                                 input logic br, input logic j, input logic jr,
                                 input logic inv, input logic zero,
                                 input logic [31:0] da);
        logic [31:0] p4;
        logic [31:0] np;
        shortint     off;
        int          waits;
        waits = 0;
        while (imem_req !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        checkOutput("fetchReq",  imem_req, 1'b1);
        checkOutput("fetchAddr", imem_addr, mPc);
        // Waiting cycles: flags toggle at random and must be ignored
        for (int i = 0; i < delay; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            Branch     = 1'($urandom);
            Jump       = 1'($urandom);
            JumpReg    = 1'($urandom);
            Da         = $urandom;
            @(negedge clk);
        end
        checkOutput("waitReq",   imem_req, 1'b1);
        checkOutput("waitFault", fault, 1'b0);
        clearFlags();
        imem_ready = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        checkOutput("execValid", instr_valid, 1'b1);
        checkOutput("execInstr", instruction, word);
        checkOutput("execPc",    pc, mPc);
        checkOutput("execLink",  pc_plus4, mPc + 32'd4);
        checkOutput("execReq",   imem_req, 1'b0);
        checkOutput("execCount", instr_count, mCount);
        Branch  = br;
        Jump    = j;
        JumpReg = jr;
        InvZero = inv;
        Zero    = zero;
        Da      = da;
        p4 = mPc + 32'd4;
        off = word[15:0];
        if (jr)
            np = da;
        else if (j)
            np = {p4[31:28], word[25:0], 2'b00};
        else if (br && (zero != inv))
            np = p4 + 32'(int'(off) * 4);
        else
            np = p4;
        @(negedge clk);
        clearFlags();
        Da = $urandom;
        if (np[1:0] == 2'b00) begin
            mPc    = np;
            mCount = mCount + 32'd1;
            checkOutput("nextPc",    pc, mPc);
            checkOutput("nextCount", instr_count, mCount);
            checkOutput("nextFault", fault, 1'b0);
            checkOutput("nextReq",   imem_req, 1'b1);
        end else begin
            mFault = 1'b1;
            checkOutput("misFault", fault, 1'b1);
            checkOutput("misCode",  {30'h0, fault_code}, 32'h2);
            checkOutput("misPc",    pc, mPc);
            checkOutput("misCount", instr_count, mCount);
            checkOutput("misReq",   imem_req, 1'b0);
        end
    endtask

    initial begin
        int          delay;
        logic [31:0] da;
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        clearFlags();
        @(negedge clk);

        // Reset, first request timing, straight-line run
        doReset();
        @(negedge clk);
        checkOutput("firstReq", imem_req, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("seqPc", pc, 32'h10);

        // beq taken forward, beq backward onto itself, bne not taken
        applyStimulus(0, 32'h1000_0003, 1, 0, 0, 0, 1, 32'h0);
        checkOutput("beqTaken", pc, 32'h20);
        applyStimulus(0, 32'h1000_FFFF, 1, 0, 0, 0, 1, 32'h0);
        checkOutput("beqBack", pc, 32'h20);
        applyStimulus(0, 32'h1400_0003, 1, 0, 0, 1, 1, 32'h0);
        checkOutput("bneNot", pc, 32'h24);

        // Ready on the last allowed waiting cycle is still accepted
        applyStimulus(IMEM_TIMEOUT - 1, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("toutEdgePc", pc, 32'h28);

        // One more waiting cycle than that trips the timeout
        for (int i = 1; i <= IMEM_TIMEOUT; i++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            if (i == IMEM_TIMEOUT - 1) begin
                checkOutput("toutPreFault", fault, 1'b0);
                checkOutput("toutPreReq",   imem_req, 1'b1);
            end
        end
        checkOutput("toutFault", fault, 1'b1);
        checkOutput("toutCode",  {30'h0, fault_code}, 32'h1);
        checkOutput("toutReq",   imem_req, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        imem_ready = 1'b0;
        checkOutput("toutHoldCode",  {30'h0, fault_code}, 32'h1);
        checkOutput("toutHoldValid", instr_valid, 1'b0);
        checkOutput("toutHoldPc",    pc, 32'h28);

        // jal, then jr winning over jal, then misaligned jr
        doReset();
        applyStimulus(0, 32'h0C00_0040, 0, 1, 0, 0, 0, 32'h0);
        checkOutput("jalPc", pc, 32'h100);
        applyStimulus(0, 32'h0C00_0040, 0, 1, 1, 0, 0, 32'h0000_0200);
        checkOutput("jrPc", pc, 32'h200);
        applyStimulus(0, 32'h0, 0, 0, 1, 0, 0, 32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            imem_ready = 1'b1;
            JumpReg    = 1'b1;
            Da         = 32'h0000_0300;
            @(negedge clk);
            checkOutput("faultReqLow", imem_req, 1'b0);
        end
        clearFlags();
        imem_ready = 1'b0;
        checkOutput("faultPcFrozen", pc, 32'h200);
        checkOutput("faultCodeHeld", {30'h0, fault_code}, 32'h2);
        doReset();
        applyStimulus(0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("restartPc", pc, RESET_PC + 32'd4);

        // Randomised program run against the model
        for (int n = 0; n < 80; n++) begin
            delay = ($urandom_range(0, 7) == 0) ? IMEM_TIMEOUT - 1 : int'($urandom_range(0, 2));
            da    = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(delay, $urandom,
                          1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom), 1'($urandom), da);
            if (mFault)
                doReset();
        end

        // Reset during a fetch that memory answers in the same cycle
        applyStimulus(0, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("preRstReq", imem_req, 1'b1);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        reset      = 1'b0;
        imem_ready = 1'b0;
        checkOutput("midRstInstr", instruction, 32'h0);
        checkOutput("midRstCount", instr_count, 32'h0);
        checkOutput("midRstPc",    pc, RESET_PC);
        checkOutput("midRstReq",   imem_req, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
